// File: rtl/uart_rx_char_if.sv
// uart_rx_char_if: serial line in; received byte and status strobes out.
// master = receiver (rx in; dato/sign/frame_err/par_err/busy out), slave = consumer.
interface uart_rx_char_if;
  logic       rx;
  logic [7:0] dato;
  logic       sign;
  logic       frame_err;
  logic       par_err;
  logic       busy;

  modport master (
    input  rx,
    output dato, sign, frame_err, par_err, busy
  );

  modport slave (
    output rx,
    input  dato, sign, frame_err, par_err, busy
  );
endinterface

// File: rtl/uart_rx_char.sv
// uart_rx_char: 8N1 UART receiver, 16x oversampling, byte + 1-clk sign strobe.
// Ports: clk, reset (async, high), bus (uart_rx_char_if.master). Parity: UART_RX_PARITY_EN.
module uart_rx_char #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic           clk,
  input  logic           reset,
  uart_rx_char_if.master bus
);
  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] TMAX = TW'(DIV - 1);
  localparam logic [3:0] SMID = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] SMAX = 4'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    ARM, IDLE, START, DATA, PARITY, STOP
  } state_t;

  state_t        state;
  logic          s1;
  logic          rxs;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [3:0]    s_cnt;
  logic [2:0]    n_cnt;
  logic [7:0]    shreg;
  logic [7:0]    dato_q;
  logic          sign_q;
  logic          ferr_q;
  logic          perr_q;
`ifdef UART_RX_PARITY_EN
  logic          par_bad;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1  <= 1'b1;
      rxs <= 1'b1;
    end else begin
      s1  <= bus.rx;
      rxs <= s1;
    end
  end

  assign tick = (tick_cnt == TMAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      tick_cnt <= '0;
    else if (state == ARM || state == IDLE || tick)
      tick_cnt <= '0;
    else
      tick_cnt <= tick_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ARM;
      s_cnt  <= '0;
      n_cnt  <= '0;
      shreg  <= '0;
      dato_q <= '0;
      sign_q <= 1'b0;
      ferr_q <= 1'b0;
      perr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      sign_q <= 1'b0;
      ferr_q <= 1'b0;
      perr_q <= 1'b0;
      unique case (state)
        // Synchronizer flops come out of reset at 1; wait until
        // they have flushed before trusting rxs as "line high".
        ARM: begin
          if (s_cnt != 4'd2) begin
            s_cnt <= s_cnt + 1'b1;
          end else if (rxs) begin
            s_cnt <= '0;
            state <= IDLE;
          end
        end
        IDLE: begin
          s_cnt <= '0;
          if (!rxs)
            state <= START;
        end
        START: begin
          if (tick) begin
            if (s_cnt == SMID) begin
              s_cnt <= '0;
              n_cnt <= '0;
              state <= rxs ? IDLE : DATA;
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (s_cnt == SMAX) begin
              s_cnt        <= '0;
              shreg[n_cnt] <= rxs;
              n_cnt        <= n_cnt + 1'b1;
              if (n_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            if (s_cnt == SMAX) begin
              s_cnt   <= '0;
              par_bad <= rxs ^ (^shreg);
              state   <= STOP;
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end
`endif
        // Back to IDLE at mid-stop so the second half of the
        // stop bit is available to catch a back-to-back start.
        STOP: begin
          if (tick) begin
            if (s_cnt == SMAX) begin
              s_cnt <= '0;
              state <= IDLE;
              if (!rxs) begin
                ferr_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
              end else if (par_bad) begin
                perr_q <= 1'b1;
`endif
              end else begin
                dato_q <= shreg;
                sign_q <= 1'b1;
              end
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end
        default: state <= ARM;
      endcase
    end
  end

  assign bus.dato      = dato_q;
  assign bus.sign      = sign_q;
  assign bus.frame_err = ferr_q;
  assign bus.par_err   = perr_q;
  assign bus.busy      = (state != ARM) && (state != IDLE);
endmodule
